top_vector_sequencer: RTL
=========================

# top_vector_sequencer

Hardware stimulus sequencer for the TOP datapath. It holds a small table of input vectors and expected outputs. On `start` it applies each vector to TOP's X/Y/Z inputs, waits a programmable settle time, and compares TOP's A/B/C outputs against the expected values. Pass/fail counts and the first failing index are reported, so the same vector sets the Python testbench flow generates can run on-chip without a simulator.

## Interface
Parameters:
- `ADDR_W`, 4: vector table address width; DEPTH = 2**ADDR_W entries.
- `SETTLE`, 1: cycles between driving a vector and comparing outputs; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `num_vec`  in  ADDR_W+1  vectors to run, sampled with `start`; values above DEPTH clamp to DEPTH
- `wr_en`  in  1  table write strobe; ignored while `busy`
- `wr_addr`  in  ADDR_W  table entry
- `wr_stim`  in  15  stimulus {X, Y[7:0], Z[0:5]}; X is bit 14
- `wr_exp`  in  34  expected {A[31:0], B, C}; C is bit 0
- `x_o`  out  1  to TOP.X
- `y_o`  out  8  to TOP.Y
- `z_o`  out  6  to TOP.Z; Z index 0 maps to `z_o[5]`
- `a_i`  in  32  from TOP.A
- `b_i`  in  1  from TOP.B
- `c_i`  in  1  from TOP.C
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `pass_cnt`  out  ADDR_W+1  vectors matched
- `fail_cnt`  out  ADDR_W+1  vectors mismatched
- `first_fail_vld`  out  1  at least one mismatch this run
- `first_fail_idx`  out  ADDR_W  index of first mismatch

## Operation
- Table: DEPTH x 49-bit synchronous-write register array. It is not cleared by reset.
- FSM states are IDLE, DRIVE and WAIT.
- **IDLE**
  - When `start` is high, the controller latches the clamped `num_vec` and clears both counters, `first_fail_vld` and `first_fail_idx`.
  - If the latched count is 0, it pulses `done`, stays in IDLE and never asserts `busy`.
  - Otherwise it sets idx=0 and `busy`=1, and moves to DRIVE.
- **DRIVE**
  - Registers `x_o`/`y_o`/`z_o` from table[idx].
  - Loads the settle counter with SETTLE and moves to WAIT.
- **WAIT**
  - Decrements the settle counter each edge.
  - On the edge where the counter reaches 0, it compares {a_i, b_i, c_i} against exp[idx] over all 34 bits.
    - Match: increment `pass_cnt`.
    - Mismatch: increment `fail_cnt`. If `first_fail_vld` is 0, set it and capture idx.
  - If idx = latched count - 1: pulse `done`, clear `busy`, go to IDLE. Otherwise idx+1 and go to DRIVE.
- `x_o`/`y_o`/`z_o` hold the last applied vector after a run.
- Counters and first-fail fields hold until the next accepted `start`.
- `start` is ignored while `busy`.
- `wr_en` during a run is dropped, so the table cannot change under a run.
- Counter width ADDR_W+1 holds DEPTH without wrap.

## Timing
- Reset values: `x_o`=0, `y_o`=0, `z_o`=0, `busy`=0, `done`=0, `pass_cnt`=0, `fail_cnt`=0, `first_fail_vld`=0, `first_fail_idx`=0. State returns to IDLE.
- Reset asserted mid-run aborts on the next edge. No `done` is produced.
- Let E0 be the edge that accepts `start`:
  - Vector k is driven at edge E0+1+k*(1+SETTLE).
  - Vector k is compared at edge E0+(k+1)*(1+SETTLE).
  - `done` is high for the single cycle following edge E0+N*(1+SETTLE).
- `busy` rises at E0 and falls at the same edge `done` rises.
- A new `start` can be accepted in the cycle `done` is high, since the FSM is already in IDLE.
- Combinational path TOP -> `a_i`/`b_i`/`c_i` must settle within SETTLE cycles.

## Configuration
- Macro: `TOP_SEQ_STOP_ON_FAIL_EN`.
- Defined: the first mismatch ends the run at its compare edge.
  - `done` pulses and `busy` falls at that edge.
  - The remaining vectors are not driven.
  - `pass_cnt` + `fail_cnt` = index of the failure + 1.
- Undefined: all N vectors always run; `fail_cnt` can reach N.

## Test plan
- Reset with outputs forced high, then reset released -> all outputs 0, `busy`=0, no `done`.
- TOP model correct, 10 vectors loaded, SETTLE=1, `num_vec`=10 -> `done` at edge E0+20, `pass_cnt`=10, `fail_cnt`=0, `first_fail_vld`=0.
- exp[3] and exp[7] corrupted in bit C, `num_vec`=10:
  - Undefined: `fail_cnt`=2, `pass_cnt`=8, `first_fail_idx`=3.
  - `TOP_SEQ_STOP_ON_FAIL_EN`: `done` at E0+8, `pass_cnt`=3, `fail_cnt`=1.
- `num_vec`=0 -> `done` pulse one cycle after `start`, `busy` never high, counters 0. `num_vec`=31 with ADDR_W=4 -> 16 vectors run.
- `start` and `wr_en` pulsed during a run -> run length unchanged, table unchanged. Reset asserted at vector 5 -> IDLE next edge, no `done`.
- Vector stim {X=1, Y=8'hA5, Z index0=1 rest 0} -> `x_o`=1, `y_o`=8'hA5, `z_o`=6'b100000.

Source files
------------

// File: rtl/top_vector_sequencer.sv
// -----------------------------------------------------------------------------
// top_vector_sequencer
//
// On-chip stimulus sequencer for the TOP datapath. A small table holds input
// vectors and expected outputs. A run applies each vector to TOP's X/Y/Z
// inputs, waits SETTLE cycles for TOP to settle, and compares TOP's A/B/C
// outputs with the expected value. The run reports pass/fail counts and the
// index of the first failing vector.
//
// Build option:
//   TOP_SEQ_STOP_ON_FAIL_EN  - when defined, the first mismatch ends the run
//                              at its compare edge. When undefined, every
//                              requested vector is always run.
//
// Parameters:
//   ADDR_W  vector table address width, DEPTH = 2**ADDR_W entries
//   SETTLE  cycles from driving a vector to comparing outputs (1..15)
//
// Ports:
//   clk             system clock, all state on the rising edge
//   rst             synchronous active-high reset
//   start           begin a run (accepted only when idle)
//   num_vec         vectors to run, clamped to DEPTH, sampled with start
//   wr_en           table write strobe, dropped while busy
//   wr_addr         table entry to write
//   wr_stim         stimulus {X, Y[7:0], Z[0:5]}, X is bit 14
//   wr_exp          expected {A[31:0], B, C}, C is bit 0
//   x_o/y_o/z_o     drive TOP.X / TOP.Y / TOP.Z (Z index 0 is z_o[5])
//   a_i/b_i/c_i     observe TOP.A / TOP.B / TOP.C
//   busy            run in progress
//   done            one-cycle pulse at the end of a run
//   pass_cnt        vectors that matched
//   fail_cnt        vectors that mismatched
//   first_fail_vld  at least one mismatch in this run
//   first_fail_idx  index of the first mismatch
// -----------------------------------------------------------------------------
module top_vector_sequencer #(
   parameter int ADDR_W = 4,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_vec,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [14:0]       wr_stim,
   input  logic [33:0]       wr_exp,
   output logic              x_o,
   output logic [7:0]        y_o,
   output logic [5:0]        z_o,
   input  logic [31:0]       a_i,
   input  logic              b_i,
   input  logic              c_i,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   pass_cnt,
   output logic [ADDR_W:0]   fail_cnt,
   output logic              first_fail_vld,
   output logic [ADDR_W-1:0] first_fail_idx
);

   localparam int              DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      SETTLE_L = 4'(SETTLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT
   } state_t;

   // Table entry layout: [48:34] stimulus, [33:0] expected response.
   logic [48:0]       tbl_q [DEPTH];

   state_t            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W:0]   num_q;
   logic [3:0]        cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              x_q;
   logic [7:0]        y_q;
   logic [5:0]        z_q;
   logic [ADDR_W:0]   pass_q;
   logic [ADDR_W:0]   fail_q;
   logic              ffv_q;
   logic [ADDR_W-1:0] ffi_q;

   logic [48:0]       ent;
   logic [14:0]       ent_stim;
   logic [33:0]       ent_exp;
   logic [ADDR_W:0]   num_clamp;
   logic              mismatch;
   logic              last_vec;
   logic              settle_end;
   logic              stop_now;

   // Table write port; the table only changes between runs.
   always_ff @(posedge clk) begin
      if (wr_en && !busy_q) begin
         tbl_q[wr_addr] <= {wr_stim, wr_exp};
      end
   end

   always_comb begin
      ent        = tbl_q[idx_q];
      ent_stim   = ent[48:34];
      ent_exp    = ent[33:0];
      num_clamp  = (num_vec > DEPTH_L) ? DEPTH_L : num_vec;
      mismatch   = ({a_i, b_i, c_i} != ent_exp);
      // num_q is never 0 while a run is active, so the subtraction cannot wrap.
      last_vec   = ({1'b0, idx_q} == (num_q - 1'b1));
      // The counter is loaded with SETTLE in DRIVE; the edge that takes it
      // from 1 to 0 is the compare edge.
      settle_end = (cnt_q == 4'd1);
`ifdef TOP_SEQ_STOP_ON_FAIL_EN
      stop_now   = last_vec || mismatch;
`else
      stop_now   = last_vec;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= 1'b0;
         y_q     <= '0;
         z_q     <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         ffv_q   <= 1'b0;
         ffi_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  num_q  <= num_clamp;
                  pass_q <= '0;
                  fail_q <= '0;
                  ffv_q  <= 1'b0;
                  ffi_q  <= '0;
                  idx_q  <= '0;
                  if (num_clamp == '0) begin
                     // Empty run: report completion without ever going busy.
                     done_q <= 1'b1;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= S_DRIVE;
                  end
               end
            end

            S_DRIVE: begin
               // Z index 0 already sits in the MSB of the stimulus Z field,
               // which is where z_o[5] expects it.
               x_q     <= ent_stim[14];
               y_q     <= ent_stim[13:6];
               z_q     <= ent_stim[5:0];
               cnt_q   <= SETTLE_L;
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (settle_end) begin
                  if (mismatch) begin
                     fail_q <= fail_q + 1'b1;
                     if (!ffv_q) begin
                        ffv_q <= 1'b1;
                        ffi_q <= idx_q;
                     end
                  end else begin
                     pass_q <= pass_q + 1'b1;
                  end
                  if (stop_now) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= S_DRIVE;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign x_o            = x_q;
   assign y_o            = y_q;
   assign z_o            = z_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign first_fail_vld = ffv_q;
   assign first_fail_idx = ffi_q;

endmodule
